bcd_to_binary: RTL
==================

// Module: bcd_to_binary
// PURPOSE
//  Converts a packed multi-digit BCD value (e.g. a lag count or frame count) back to plain
//  binary so downstream logic can compare, average or threshold it. Uses a sequential
//  reverse double-dabble: one shift per clock, valid/ready handshake on both sides.
//  Sits between the BCD counters and arithmetic or statistics logic in the measurement path.
// PARAMETERS
//  DIGITS     6   number of BCD digits in bcd_in (digit 0 = bits [3:0], least significant)
//  BIN_WIDTH  20  result width; must satisfy 2**BIN_WIDTH > 10**DIGITS - 1 (20 covers 999999)
// PORTS
//  clock      in   1            system clock, all logic on rising edge
//  reset      in   1            reset, synchronous, active-high
//  in_valid   in   1            bcd_in holds a value to convert
//  in_ready   out  1            block can accept a value (IDLE only)
//  bcd_in     in   4*DIGITS     packed BCD input, sampled on accept
//  out_valid  out  1            bin_out holds a finished result
//  out_ready  in   1            consumer takes result
//  bin_out    out  BIN_WIDTH    binary result
//  error      out  1            invalid digit seen (present only with BCD2BIN_CHECK_EN)
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, out_valid=0, bin_out=0, error=0, shift count=0.
//  - States: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: in_ready=1. Accept edge T = in_valid & in_ready: load bcd reg <= bcd_in,
//    bin reg <= 0, count <= 0, go SHIFT.
//  - SHIFT: in_ready=0. Each edge: {bcd,bin} >>= 1 (bcd LSB enters bin MSB), then every
//    4-bit digit of shifted bcd that is >= 8 has 3 subtracted (combinationally before
//    register write). count++. The shift at count==BIN_WIDTH-1 also moves state to DONE.
//  - Latency: out_valid rises after edge T+BIN_WIDTH (20 cycles default), fixed,
//    data-independent.
//  - DONE: out_valid=1, bin_out=bin reg, held stable until out_valid & out_ready; on that
//    edge out_valid<=0, go IDLE. out_ready ignored outside DONE.
//  - Throughput: one conversion per BIN_WIDTH+2 cycles min; in_ready is 0 in SHIFT and DONE
//    (no overlap, no same-cycle accept on DONE exit). in_valid while busy is ignored, not queued.
//  - Arithmetic: bin reg exactly BIN_WIDTH bits; after BIN_WIDTH shifts bcd reg is zero
//    for legal input. All digit corrections are 4-bit, no carries between digits.
//  - Reset mid-SHIFT or mid-DONE: conversion discarded, no out_valid pulse, back to IDLE
//    on next cycle.
//  - bin_out changes only on the DONE-entry edge; it holds the last result while IDLE/SHIFT.
// CONFIGURATION
//  BCD2BIN_CHECK_EN defined: on accept, any digit > 9 sets error<=1, bin reg <= 0, state
//    goes straight to DONE (out_valid after T+1); error cleared on the out handshake and by
//    reset. Legal input: error=0, timing identical to the unchecked build.
//  BCD2BIN_CHECK_EN undefined: no error port, no check; illegal digits run the normal
//    algorithm and give a deterministic but meaningless bin_out.
// TESTING
//  bcd_in=0x000000 accepted -> after 20 cycles out_valid=1, bin_out=0.
//  bcd_in=0x999999 -> bin_out=0xF423F (999999), out_valid exactly 20 cycles after accept.
//  bcd_in=0x123456 with out_ready low 5 cycles in DONE -> bin_out=0x1E240 held stable,
//    in_ready=0 throughout, single handshake.
//  in_valid held high with 0x000042 then 0x000017 back to back -> second accepted only after
//    first output handshake; results 42 then 17.
//  reset pulsed at 10th SHIFT cycle of 0x555555 -> no out_valid, in_ready=1 next cycle, next
//    conversion of 0x000001 gives 1.
//  BCD2BIN_CHECK_EN: bcd_in=0x00000A -> out_valid after 1 cycle, error=1, bin_out=0; then
//    0x000010 -> error=0, bin_out=10.

Source files
------------

// File: rtl/bcd_to_binary.sv
// bcd_to_binary
//   Sequential reverse double-dabble: converts a packed multi-digit BCD value to
//   plain binary, one shift per clock, with valid/ready handshakes on both sides.
//   Latency from accept to out_valid is BIN_WIDTH cycles, independent of data.
//
// Parameters
//   DIGITS     number of BCD digits in bcd_in (digit 0 = bits [3:0])
//   BIN_WIDTH  result width; 2**BIN_WIDTH must exceed 10**DIGITS - 1
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   in_valid   bcd_in holds a value to convert
//   in_ready   block can accept a value (idle only)
//   bcd_in     packed BCD input, sampled on accept
//   out_valid  bin_out holds a finished result
//   out_ready  consumer takes the result
//   bin_out    binary result, held until the next conversion completes
//   error      invalid digit seen on accept (only when BCD2BIN_CHECK_EN is defined)
//
// Build option
//   BCD2BIN_CHECK_EN  when defined, an input digit > 9 skips the conversion, raises
//                     error and presents a zero result on the next cycle.

module bcd_to_binary #(
    parameter int DIGITS    = 6,
    parameter int BIN_WIDTH = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_WIDTH-1:0]  bin_out
`ifdef BCD2BIN_CHECK_EN
    ,
    output logic                  error
`endif
);

    localparam int CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state, next_state;
    logic [4*DIGITS-1:0]    bcd_r, bcd_next;
    logic [BIN_WIDTH-1:0]   bin_r, bin_next;
    logic [CW-1:0]          count;
    logic                   last_shift;
    logic                   bad_digit;

    assign last_shift = (count == CW'(BIN_WIDTH - 1));

    // One step: shift {bcd,bin} right, then pull every digit that reads >= 8 back
    // down by 3 (undoes the x2 the digit above contributed). No inter-digit carry.
    always_comb begin
        bin_next = {bcd_r[0], bin_r[BIN_WIDTH-1:1]};
        bcd_next = bcd_r >> 1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_next[4*i+3])
                bcd_next[4*i +: 4] = bcd_next[4*i +: 4] - 4'd3;
        end
    end

`ifdef BCD2BIN_CHECK_EN
    // Digit > 9 means bit 3 set together with bit 2 or bit 1.
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i+3] & (bcd_in[4*i+2] | bcd_in[4*i+1]))
                bad_digit = 1'b1;
        end
    end
`else
    assign bad_digit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = bad_digit ? DONE : SHIFT;
            end
            SHIFT: begin
                if (last_shift) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bcd_r   <= '0;
            bin_r   <= '0;
            count   <= '0;
            bin_out <= '0;
`ifdef BCD2BIN_CHECK_EN
            error   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bcd_r <= bcd_in;
                        bin_r <= '0;
                        count <= '0;
`ifdef BCD2BIN_CHECK_EN
                        if (bad_digit) begin
                            error   <= 1'b1;
                            bin_out <= '0;
                        end
`endif
                    end
                end
                SHIFT: begin
                    bcd_r <= bcd_next;
                    bin_r <= bin_next;
                    count <= count + CW'(1);
                    if (last_shift) bin_out <= bin_next;
                end
                DONE: begin
`ifdef BCD2BIN_CHECK_EN
                    if (out_ready) error <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
